mult_arbiter: RTL and testbench

Round-robin scheduler that shares the single-precision multiplier between two requesters (requester 0: operand memory path; requester 1: auxiliary/test path). It captures one requester's operand pair, pulses the multiplier's start, waits for its done with a watchdog, and returns the 32-bit product with a one-cycle completion pulse to the owning requester. It sits between the requesters and the multiplier and replaces direct start/done wiring.

---
 rtl/mult_arbiter.sv | 136 +++++++++++++
 tb/tb_mult_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one single-precision multiplier between two requesters.
// A watchdog aborts the operation when the multiplier's done pulse never arrives.
module mult_arbiter #(
    parameter int TIMEOUT = 200,
    parameter int CW      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] result,
    output logic        err,
    output logic        busy,
    output logic        mult_start,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    input  logic [31:0] mult_product,
    input  logic        mult_done,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 32'sd1);
    localparam logic [CW-1:0] WD_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_r;
    logic          owner_r;
    logic          last_grant_r;
    logic [CW-1:0] wd_r;
    logic          grant_any_s;
    logic          grant_sel_s;

    assign grant_any_s = req0 | req1;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_sel_s = 1'b0;
        if (req0 && req1) begin
            grant_sel_s = ~last_grant_r;
        end else if (req1) begin
            grant_sel_s = 1'b1;
        end else begin
            grant_sel_s = 1'b0;
        end
    end

    // Arbitration, operand capture, watchdog and response sequencing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            wd_r         <= {CW{1'b0}};
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            mult_start   <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            result       <= 32'd0;
            mult_a       <= 32'd0;
            mult_b       <= 32'd0;
            op_count     <= 16'd0;
        end else begin
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            mult_start <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_any_s) begin
                        mult_a     <= grant_sel_s ? a1 : a0;
                        mult_b     <= grant_sel_s ? b1 : b0;
                        owner_r    <= grant_sel_s;
                        gnt0       <= ~grant_sel_s;
                        gnt1       <= grant_sel_s;
                        mult_start <= 1'b1;
                        busy       <= 1'b1;
                        state_r    <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    wd_r    <= {CW{1'b0}};
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving on the last watchdog cycle still counts as a normal completion.
                    if (mult_done) begin
                        result   <= mult_product;
                        err      <= 1'b0;
                        op_count <= op_count + 16'd1;
                        done0    <= ~owner_r;
                        done1    <= owner_r;
                        state_r  <= ST_RESP;
                    end else if (wd_r == WD_LAST) begin
                        result  <= 32'd0;
                        err     <= 1'b1;
                        done0   <= ~owner_r;
                        done1   <= owner_r;
                        state_r <= ST_RESP;
                    end else begin
                        wd_r <= wd_r + WD_ONE;
                    end
                end
                ST_RESP: begin
                    last_grant_r <= owner_r;
                    busy         <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural multiplier stub plus a transaction-level
// reference model of round-robin service, latency and watchdog abort.
module tb_mult_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [31:0] a0, b0, a1, b1;
    logic        gnt0, gnt1, done0, done1, err, busy, mult_start;
    logic [31:0] result, mult_a, mult_b, mult_product;
    logic        mult_done;
    logic [15:0] op_count;

    logic        stub_done_r, stub_pend_r, stub_hang, spur_done;
    int          stub_lat, stub_cnt_r;
    logic [31:0] stub_a_r, stub_b_r;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        m_last;
    logic [15:0] m_count;

    mult_arbiter #(.TIMEOUT(TO), .CW(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .err(err), .busy(busy),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_product(mult_product), .mult_done(mult_done),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Behaviour of the external multiplier: 2.0*3.0 is exact, other operands use a fixed scramble.
    function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        return (a * b) ^ {b[15:0], a[31:16]};
    endfunction

    assign mult_done = stub_done_r | spur_done;

    // Multiplier stub: answers stub_lat cycles after a start unless told to hang.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            stub_done_r  <= 1'b0;
            stub_pend_r  <= 1'b0;
            stub_cnt_r   <= 0;
            stub_a_r     <= 32'd0;
            stub_b_r     <= 32'd0;
            mult_product <= 32'd0;
        end else begin
            stub_done_r <= 1'b0;
            if (mult_start && !stub_hang) begin
                stub_pend_r <= 1'b1;
                stub_cnt_r  <= stub_lat;
                stub_a_r    <= mult_a;
                stub_b_r    <= mult_b;
            end else if (stub_pend_r) begin
                if (stub_cnt_r == 1) begin
                    stub_done_r  <= 1'b1;
                    mult_product <= fmul_ref(stub_a_r, stub_b_r);
                    stub_pend_r  <= 1'b0;
                end else begin
                    stub_cnt_r <= stub_cnt_r - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One complete transaction; called at a negedge of an IDLE cycle, returns at the next IDLE negedge.
    task automatic serve(input logic r0, input logic r1,
                         input logic [31:0] x0, input logic [31:0] y0,
                         input logic [31:0] x1, input logic [31:0] y1,
                         input int lat, input logic hang, input logic spur);
        logic        sel;
        logic [31:0] ea, eb;
        int          n;
        sel = (r0 && r1) ? ~m_last : r1;
        ea  = sel ? x1 : x0;
        eb  = sel ? y1 : y0;
        stub_lat = lat;
        stub_hang = hang;
        req0 = r0; req1 = r1;
        a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        spur_done = spur;
        @(negedge clk);
        check("gnt0", 32'(gnt0), 32'(!sel));
        check("gnt1", 32'(gnt1), 32'(sel));
        check("mult_start", 32'(mult_start), 32'd1);
        check("mult_a", mult_a, ea);
        check("mult_b", mult_b, eb);
        check("busy_issue", 32'(busy), 32'd1);
        @(negedge clk);
        spur_done = 1'b0;
        n = 1;
        while (!(done0 || done1) && n < 40) begin
            check("wait_quiet", 32'(gnt0 | gnt1 | mult_start), 32'd0);
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), hang ? 32'(TO + 1) : 32'(lat + 2));
        check("done0", 32'(done0), 32'(!sel));
        check("done1", 32'(done1), 32'(sel));
        check("err", 32'(err), 32'(hang));
        check("result", result, hang ? 32'd0 : fmul_ref(ea, eb));
        if (!hang) m_count = m_count + 16'd1;
        check("op_count", 32'(op_count), 32'(m_count));
        m_last = sel;
        if (sel) req1 = 1'b0;
        else req0 = 1'b0;
        @(negedge clk);
        check("idle_quiet", 32'(busy | done0 | done1), 32'd0);
    endtask

    initial begin
        logic r0, r1;
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
        stub_hang = 1'b0; stub_lat = 1; spur_done = 1'b0;
        m_last = 1'b1; m_count = 16'd0;
        repeat (2) @(negedge clk);
        check("rst_flags", 32'({gnt0, gnt1, done0, done1, err, busy, mult_start}), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_mult_a", mult_a, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        serve(1'b1, 1'b0, 32'h4000_0000, 32'h4040_0000, 32'd0, 32'd0, 3, 1'b0, 1'b0);
        check("fp_2x3", result, 32'h40C0_0000);

        for (int i = 0; i < 4; i++)
            serve(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom, $urandom_range(1, 6), 1'b0, 1'b0);

        for (int i = 0; i < 3; i++)
            serve(1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom, $urandom_range(1, 6), 1'b0, 1'b0);

        serve(1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom, 1, 1'b1, 1'b0);
        serve(1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom, 2, 1'b0, 1'b0);
        serve(1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom, TO - 1, 1'b0, 1'b0);
        serve(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom, 3, 1'b0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            serve(r0, r1, $urandom, $urandom, $urandom, $urandom, $urandom_range(1, 10),
                  ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a WAIT phase.
        stub_hang = 1'b1;
        req0 = 1'b1; req1 = 1'b0; a0 = $urandom; b0 = $urandom;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_flags", 32'({gnt0, gnt1, done0, done1, err, busy, mult_start}), 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_op_count", 32'(op_count), 32'd0);
        check("mid_rst_mult_b", mult_b, 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        stub_hang = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'(done0 | done1 | busy), 32'd0);
        end
        m_last = 1'b1; m_count = 16'd0;
        serve(1'b1, 1'b0, 32'h4000_0000, 32'h4040_0000, 32'd0, 32'd0, 4, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
